// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
// Shared widths and constants for the writeback stage and register file.
//   LEN_DATA     : register / datapath width
//   LEN_INST_REG : register index width
//   NUM_REGS     : architectural register count (2**LEN_INST_REG)
//   REG_ZERO     : index of the hard-wired zero register
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

    localparam int LEN_DATA     = 32;
    localparam int LEN_INST_REG = 5;
    localparam int NUM_REGS     = 32;

    localparam logic [LEN_INST_REG-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_data_sel.sv
// ---------------------------------------------------------------------------
// wb_data_sel
// Writeback value select and qualified write strobe. This block is purely
// combinational so that the forwarding unit can reuse it and see the same
// value that the register file is about to commit.
// Ports:
//   i_RegWrite  : writeback enable from MEM/WB
//   i_MemToReg  : 1 selects i_mem_data, 0 selects i_alu_data
//   i_mem_data  : load data
//   i_alu_data  : ALU result
//   i_rd        : destination register index
//   o_wb_data   : selected writeback value
//   o_wb_en     : write strobe, never asserted for the zero register
// ---------------------------------------------------------------------------
module wb_data_sel
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = LEN_DATA,
    parameter int ADDR_W = LEN_INST_REG
) (
    input  logic              i_RegWrite,
    input  logic              i_MemToReg,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic [ADDR_W-1:0] i_rd,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_wb_en
);

    assign o_wb_data = i_MemToReg ? i_mem_data : i_alu_data;
    assign o_wb_en   = i_RegWrite && (i_rd != '0);

endmodule

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Writeback stage plus 32-entry architectural register file. Selects the
// writeback value, commits it on posedge clk, serves the two ID-stage read
// ports and exports the writeback value for the EX forwarding mux.
//
// Build option:
//   WB_REGFILE_BYPASS_EN : when defined, a read port whose address matches a
//                          qualified write in the same cycle returns the
//                          writeback value before the edge commits it.
//                          When undefined, reads see stored data only.
//
// Ports:
//   clk         : clock, all state updates on posedge
//   rst         : asynchronous active-low reset, clears every entry
//   i_RegWrite  : writeback enable
//   i_MemToReg  : writeback source select (1 = mem, 0 = alu)
//   i_mem_data  : load data
//   i_alu_data  : ALU result
//   i_rd        : destination register index
//   i_rs_addr   : read port A index
//   i_rt_addr   : read port B index
//   o_rs_data   : read port A data
//   o_rt_data   : read port B data
//   o_wb_data   : selected writeback value
//   o_wb_en     : qualified write strobe (i_RegWrite && i_rd != 0)
// ---------------------------------------------------------------------------
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = LEN_DATA,
    parameter int ADDR_W   = LEN_INST_REG,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_RegWrite,
    input  logic              i_MemToReg,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic [ADDR_W-1:0] i_rs_addr,
    input  logic [ADDR_W-1:0] i_rt_addr,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_wb_en
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    wb_data_sel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wb_data_sel (
        .i_RegWrite (i_RegWrite),
        .i_MemToReg (i_MemToReg),
        .i_mem_data (i_mem_data),
        .i_alu_data (i_alu_data),
        .i_rd       (i_rd),
        .o_wb_data  (o_wb_data),
        .o_wb_en    (o_wb_en)
    );

    // Entry 0 is cleared by reset and never written because o_wb_en is
    // already qualified against the zero index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (o_wb_en) begin
            regs[i_rd] <= o_wb_data;
        end
    end

    // Reads are forced to zero while reset is held so that the bypass path
    // cannot leak writeback data during reset.
    always_comb begin
        o_rs_data = '0;
        if (rst && (i_rs_addr != '0)) begin
            o_rs_data = regs[i_rs_addr];
`ifdef WB_REGFILE_BYPASS_EN
            if (o_wb_en && (i_rs_addr == i_rd)) begin
                o_rs_data = o_wb_data;
            end
`endif
        end
    end

    always_comb begin
        o_rt_data = '0;
        if (rst && (i_rt_addr != '0)) begin
            o_rt_data = regs[i_rt_addr];
`ifdef WB_REGFILE_BYPASS_EN
            if (o_wb_en && (i_rt_addr == i_rd)) begin
                o_rt_data = o_wb_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        i_RegWrite;
    logic        i_MemToReg;
    logic [31:0] i_mem_data;
    logic [31:0] i_alu_data;
    logic [4:0]  i_rd;
    logic [4:0]  i_rs_addr;
    logic [4:0]  i_rt_addr;
    logic [31:0] o_rs_data;
    logic [31:0] o_rt_data;
    logic [31:0] o_wb_data;
    logic        o_wb_en;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] model [32];

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .i_RegWrite (i_RegWrite),
        .i_MemToReg (i_MemToReg),
        .i_mem_data (i_mem_data),
        .i_alu_data (i_alu_data),
        .i_rd       (i_rd),
        .i_rs_addr  (i_rs_addr),
        .i_rt_addr  (i_rt_addr),
        .o_rs_data  (o_rs_data),
        .o_rt_data  (o_rt_data),
        .o_wb_data  (o_wb_data),
        .o_wb_en    (o_wb_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        m2r;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] exp_wb;
        logic        exp_en;
        logic [31:0] exp_rs_after;
        logic [31:0] exp_rt_after;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Spec-level expected read value given current stored state and inputs.
    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] rd, input logic [31:0] wb);
        if (a == 5'd0) return 32'h0;
        if (BYPASS && we && rd != 5'd0 && a == rd) return wb;
        return model[a];
    endfunction

    task automatic drive(input logic we, input logic m2r, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt);
        i_RegWrite = we;
        i_MemToReg = m2r;
        i_mem_data = mem;
        i_alu_data = alu;
        i_rd       = rd;
        i_rs_addr  = rs;
        i_rt_addr  = rt;
    endtask

    // Advance through one posedge, updating the model as the spec dictates.
    task automatic edge_commit();
        logic [31:0] wb;
        wb = i_MemToReg ? i_mem_data : i_alu_data;
        @(posedge clk);
        if (rst && i_RegWrite && i_rd != 5'd0) model[i_rd] = wb;
        #1;
    endtask

    initial begin
        logic [31:0] wbv;
        logic        r_we, r_m2r;
        logic [31:0] r_mem, r_alu;
        logic [4:0]  r_rd, r_rs, r_rt;

        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

        vecs[0] = '{1'b1, 1'b1, 32'h11112222, 32'h33334444, 5'd7, 5'd7, 5'd0,
                    32'h11112222, 1'b1, 32'h11112222, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h11112222, 32'h33334444, 5'd7, 5'd7, 5'd7,
                    32'h33334444, 1'b1, 32'h33334444, 32'h33334444};
        vecs[2] = '{1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0,
                    32'hFFFFFFFF, 1'b0, 32'h0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h0, 32'h00000001, 5'd9, 5'd9, 5'd7,
                    32'h00000001, 1'b1, 32'h00000001, 32'h33334444};
        vecs[4] = '{1'b0, 1'b1, 32'h5A5A5A5A, 32'hA5A5A5A5, 5'd9, 5'd9, 5'd7,
                    32'h5A5A5A5A, 1'b0, 32'h00000001, 32'h33334444};

        // Reset state: write attempted while held in reset is blocked.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h77777777, 5'd4, 5'd4, 5'd4);
        #1;
        chk("rst_rs_hold", o_rs_data, 32'h0);
        chk("rst_rt_hold", o_rt_data, 32'h0);
        edge_commit();
        chk("rst_write_blocked", o_rs_data, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        rst = 1'b1;

        // Table-driven vectors.
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            drive(vecs[v].we, vecs[v].m2r, vecs[v].mem, vecs[v].alu,
                  vecs[v].rd, vecs[v].rs, vecs[v].rt);
            #1;
            chk($sformatf("vec%0d_wb_data", v), o_wb_data, vecs[v].exp_wb);
            chk($sformatf("vec%0d_wb_en", v), {31'h0, o_wb_en}, {31'h0, vecs[v].exp_en});
            chk($sformatf("vec%0d_rs_pre", v), o_rs_data,
                ref_read(vecs[v].rs, vecs[v].we, vecs[v].rd, vecs[v].exp_wb));
            chk($sformatf("vec%0d_rt_pre", v), o_rt_data,
                ref_read(vecs[v].rt, vecs[v].we, vecs[v].rd, vecs[v].exp_wb));
            edge_commit();
            chk($sformatf("vec%0d_rs_post", v), o_rs_data, vecs[v].exp_rs_after);
            chk($sformatf("vec%0d_rt_post", v), o_rt_data, vecs[v].exp_rt_after);
        end

        // Same-cycle read/write on r9 (holds 0x1, writing 0xAA).
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h000000AA, 32'h0, 5'd9, 5'd9, 5'd9);
        #1;
        chk("r9_rs_pre", o_rs_data, BYPASS ? 32'h000000AA : 32'h00000001);
        chk("r9_rt_pre", o_rt_data, BYPASS ? 32'h000000AA : 32'h00000001);
        edge_commit();
        chk("r9_rs_post", o_rs_data, 32'h000000AA);
        chk("r9_rt_post", o_rt_data, 32'h000000AA);

        // Disabled write keeps r3 across 4 edges.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'hCAFE0003, 5'd3, 5'd3, 5'd3);
        edge_commit();
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h12345678, 32'h12345678, 5'd3, 5'd3, 5'd3);
        for (int k = 0; k < 4; k++) begin
            edge_commit();
            chk($sformatf("r3_hold%0d", k), o_rs_data, 32'hCAFE0003);
        end

        // Full sweep.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 32'h0, i * 32'h01010101, i[4:0], 5'd0, 5'd0);
            edge_commit();
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            i_rs_addr = i[4:0];
            i_rt_addr = 5'(31 - i);
            #1;
            chk($sformatf("sweep_rs%0d", i), o_rs_data, i * 32'h01010101);
            chk($sformatf("sweep_rt%0d", 31 - i), o_rt_data, (31 - i) * 32'h01010101);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            r_we  = 1'($urandom_range(0, 1));
            r_m2r = 1'($urandom_range(0, 1));
            r_mem = $urandom;
            r_alu = $urandom;
            r_rd  = 5'($urandom_range(0, 31));
            r_rs  = (n % 4 == 0) ? r_rd : 5'($urandom_range(0, 31));
            r_rt  = (n % 5 == 0) ? r_rd : 5'($urandom_range(0, 31));
            drive(r_we, r_m2r, r_mem, r_alu, r_rd, r_rs, r_rt);
            wbv = r_m2r ? r_mem : r_alu;
            #1;
            chk("rnd_wb_data", o_wb_data, wbv);
            chk("rnd_wb_en", {31'h0, o_wb_en}, {31'h0, r_we && r_rd != 5'd0});
            chk("rnd_rs", o_rs_data, ref_read(r_rs, r_we, r_rd, wbv));
            chk("rnd_rt", o_rt_data, ref_read(r_rt, r_we, r_rd, wbv));
            edge_commit();
        end

        // Asynchronous reset mid-cycle, pending write discarded.
        @(negedge clk);
        drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h0, 5'd5, 5'd5, 5'd5);
        edge_commit();
        chk("r5_written", o_rs_data, 32'hDEADBEEF);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h55555555, 5'd5, 5'd5, 5'd5);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        chk("async_rst_rs", o_rs_data, 32'h0);
        chk("async_rst_rt", o_rt_data, 32'h0);
        edge_commit();
        chk("rst_pending_dropped", o_rs_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 32'h0000600D, 5'd6, 5'd6, 5'd5);
        edge_commit();
        chk("first_write_after_rst", o_rs_data, 32'h0000600D);
        chk("r5_after_rst", o_rt_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB interface: takes the writeback bundle (RegWrite, MemToReg, mem data, ALU data, rd) and performs the writeback stage.
- Selects the writeback value and commits it into the 32-entry architectural register file.
- Serves the two ID-stage read ports (rs, rt).
- Exports the selected writeback value for the EX-stage forwarding mux.

Parameters:
- DATA_W, `LEN_DATA (32): register and data width.
- ADDR_W, `LEN_INST_REG (5): register index width.
- NUM_REGS, 32: number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- i_RegWrite  input  1  writeback enable from MEM/WB.
- i_MemToReg  input  1  1 selects i_mem_data, 0 selects i_alu_data.
- i_mem_data  input  DATA_W  load data from MEM/WB.
- i_alu_data  input  DATA_W  ALU result from MEM/WB.
- i_rd  input  ADDR_W  destination register index.
- i_rs_addr  input  ADDR_W  read port A index (ID stage).
- i_rt_addr  input  ADDR_W  read port B index (ID stage).
- o_rs_data  output  DATA_W  read port A data.
- o_rt_data  output  DATA_W  read port B data.
- o_wb_data  output  DATA_W  selected writeback value, to forwarding mux.
- o_wb_en  output  1  qualified write strobe: i_RegWrite && (i_rd != 0).

Behaviour:
- Reset: rst low immediately clears all NUM_REGS entries to 0, independent of clk.
  - While rst is low, writes are blocked and both read ports return 0.
  - After rst goes high, the first write takes effect on the first posedge.
- Writeback select is combinational: o_wb_data = i_MemToReg ? i_mem_data : i_alu_data. No latency.
- Write:
  - On posedge clk with rst high and o_wb_en = 1, entry[i_rd] <= o_wb_data.
  - Effective write latency is 1 cycle.
- Register 0:
  - Writes to index 0 are dropped; o_wb_en = 0 for i_rd = 0, whatever i_RegWrite is.
  - Reads of index 0 always return 0, with or without bypass.
- Reads are combinational from storage, zero-cycle latency. Exception: the optional bypass below.
- Simultaneous events:
  - rs and rt may address the same register; both ports return the same value.
  - A write and two reads may all occur in the same cycle.
- Mid-operation reset: rst asserting in the same cycle as a pending write discards the write. The entry reads 0 afterwards.
- X-safety: with i_RegWrite = 0, i_rd, i_mem_data and i_alu_data are don't-care and must not alter any state.
- No width conversion: all data paths are DATA_W end to end, with no sign or zero extension.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: write-through bypass. If o_wb_en = 1 and a read address equals i_rd, that port returns o_wb_data in the same cycle, before the edge commits. The ID stage then reads a value being written back in the same cycle, which removes one stall cycle from the hazard unit.
- Undefined: the read port returns the old stored value until after the edge. The hazard unit must stall one extra cycle for a WB-to-ID dependency. o_wb_data and o_wb_en behave identically in both builds.

Decomposition:
- Add to defs.v:
  - `LEN_DATA and `LEN_INST_REG (existing).
  - New `NUM_REGS (32).
  - New `REG_ZERO (5'd0).
- One sub-module, wb_data_sel: the combinational MemToReg mux plus the o_wb_en qualification. Reused by the forwarding unit.
- Storage array, write logic and read/bypass logic stay in wb_regfile.

Test Plan:
- Reset: write 0xDEADBEEF to r5, pull rst low mid-cycle (asynchronously) -> o_rs_data with rs=5 reads 0x00000000 immediately, before any clock edge.
- Select and latency: i_RegWrite=1, i_MemToReg=1, mem=0x11112222, alu=0x33334444, rd=7 -> o_wb_data=0x11112222 and o_wb_en=1 that cycle; after the edge, rs=7 reads 0x11112222. Repeat with MemToReg=0 -> 0x33334444.
- Register 0: i_RegWrite=1, rd=0, alu=0xFFFFFFFF -> o_wb_en=0; rs=0 and rt=0 read 0 after the edge.
- Same-cycle read/write on r9 (old value 0x00000001, new value 0x000000AA), rs=rt=9:
  - With WB_REGFILE_BYPASS_EN: both ports show 0xAA before the edge.
  - Without it: both show 0x1 before the edge and 0xAA after.
- Disabled write: i_RegWrite=0, rd=3, data=0x12345678 -> r3 keeps its prior value across 4 edges.
- Full sweep: write r1..r31 with value = index*0x01010101 on consecutive cycles, then read all pairs (rs=i, rt=31-i) -> every value matches; r0 reads 0.
